mru_req_arbiter: RTL and testbench
==================================

# mru_req_arbiter

Shares a single `mru_new_1tact` MRU buffer between `N_REQ` independent requesters. The arbiter picks one pending request, drives the MRU command port (`en`, `set_i`, `get_i`, `data_i`) for exactly one cycle, captures the read result for gets, and returns a response to the granted requester. It sits between the requester-side logic and the MRU instance and is the only driver of the MRU command inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: data width; equals the MRU `WIDTH`.
- `BUF_SIZE`, 8: MRU depth, a power of two. `IDX_W = $clog2(BUF_SIZE)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester request pending.
- `req_op`  in  N_REQ  per-requester op: 1 = set, 0 = get.
- `req_data`  in  N_REQ*WIDTH  flattened; slice i is `[i*WIDTH +: WIDTH]`. Set value, or read index for a get.
- `req_ready`  out  N_REQ  one-hot, one-cycle grant/accept pulse.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle completion pulse.
- `rsp_data`  out  WIDTH  get result; 0 for sets. Valid only while `rsp_valid` is nonzero.
- `mru_en`, `mru_set`, `mru_get`  out  1  drive the MRU `en`, `set_i` and `get_i` inputs.
- `mru_data`  out  WIDTH  drives the MRU `data_i` input.
- `mru_rdata`  in  WIDTH  the MRU `data_o`, valid the cycle after a get command.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, select grant index g (arbitration below).
  - Latch g, `req_op[g]` and `req_data` slice g.
  - Go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `req_ready[g]=1`.
  - `mru_en=1`.
  - `mru_set=op`, `mru_get=!op`.
  - `mru_data` = latched data for a set. For a get, it is the latched data's low `IDX_W` bits, zero-extended.
  - Next state: RESP for a set, WAIT for a get.
- **WAIT**: sample `mru_rdata` into the `rsp_data` register, then go to RESP.
- **RESP**
  - `rsp_valid[g]=1`. `rsp_data` is 0 for a set.
  - Go to IDLE. The pointer update takes effect here.
- Requester protocol:
  - Hold `req_valid`, `req_op` and `req_data` stable until `req_ready` is seen.
  - Dropping the request before then is a protocol violation. The latched op still completes.
  - A requester must not reissue before it sees its `rsp_valid`.
- Default arbitration is round-robin:
  - Search starts at `rr_ptr` and wraps modulo `N_REQ`.
  - On a grant, `rr_ptr` becomes (g+1) mod `N_REQ`.
  - `rr_ptr` resets to 0.
- `req_valid` is ignored outside IDLE.
- Exactly one command is outstanding at the MRU.
- `mru_en`, `mru_set` and `mru_get` are never high outside ISSUE.
- `mru_set` and `mru_get` are never high together.

## Timing
- All outputs are registered.
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `mru_en=0`, `mru_set=0`, `mru_get=0`, `mru_data=0`. State is IDLE and `rr_ptr=0`.
- Latency, with the request seen in IDLE at cycle T:
  - `req_ready` and the MRU command at T+1.
  - Set: `rsp_valid` at T+2.
  - Get: `mru_rdata` sampled at T+2, `rsp_valid` at T+3.
- Throughput: one set per 3 cycles, one get per 4 cycles.
- Simultaneous requests: only one grant per IDLE visit. Losers wait with `req_valid` held.
- Reset mid-operation (any state):
  - Outputs go to reset values immediately (asynchronous).
  - The in-flight op is dropped and no `rsp_valid` follows.
  - Requesters must reissue.

## Configuration
- `MRU_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest asserted index wins. `rr_ptr` is not implemented, so starvation of high indices is possible.
  - Undefined: round-robin as above.

## Structure
- Package `mru_arb_pkg` holds:
  - State enum `mru_arb_state_t` (IDLE, ISSUE, WAIT, RESP).
  - Op encoding constants `MRU_OP_SET=1'b1`, `MRU_OP_GET=1'b0`.
- Sub-module `mru_arb_pick`: combinational, `N_REQ`-wide. Takes `req_valid` and `rr_ptr` and returns a one-hot grant and its index. It contains both round-robin and fixed-priority variants under the macro.

## Test plan
- Single set: requester 0 issues set `0x00AA`.
  - T+1: `req_ready=4'b0001`, `mru_set=1`, `mru_data=0x00AA`.
  - T+2: `rsp_valid=4'b0001`, `rsp_data=0`.
- Single get: requester 2 issues get with data `0x0003`; the model returns `mru_rdata=0x1234` at T+2.
  - T+1: `mru_get=1`, `mru_data=0x0003`.
  - T+3: `rsp_valid=4'b0100`, `rsp_data=0x1234`.
- Index masking: a get with data `0xFFF9` and `BUF_SIZE=8` gives `mru_data=0x0001`.
- Contention:
  - All four requesters hold sets from reset; grants come in order 0,1,2,3, 3 cycles apart, and each releases after its `rsp_valid`.
  - With `MRU_ARB_FIXED_PRIO_EN`, requester 0 held continuously is granted every 3 cycles and requesters 1–3 never.
- Wrap-around: `rr_ptr=3`, requesters 0 and 1 pending → grant 0, then 1.
- Reset during WAIT: assert `rst_n=0`.
  - All outputs are 0 in the same cycle.
  - After release: no `rsp_valid`, state IDLE, next grant goes to requester 0.

Source files
------------

// File: rtl/mru_arb_pkg.sv
// ============================================================================
// Module  : mru_arb_pkg
// Brief   : Shared types and op encodings for the MRU request arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mru_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } mru_arb_state_t;

   localparam logic MRU_OP_SET = 1'b1;
   localparam logic MRU_OP_GET = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mru_arb_pick.sv
// ============================================================================
// Module  : mru_arb_pick
// Brief   : Combinational grant selector, round-robin from rr_ptr by default;
//           lowest-index fixed priority when MRU_ARB_FIXED_PRIO_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mru_arb_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any_req
);

   logic found;

   assign any_req = |req_valid;

`ifdef MRU_ARB_FIXED_PRIO_EN
   logic unused_rr_ptr;
   assign unused_rr_ptr = ^rr_ptr;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req_valid[k]) begin
            found     = 1'b1;
            grant[k]  = 1'b1;
            grant_idx = PTR_W'(k);
         end
      end
   end
`else
   int idx;

   // Scan N_REQ slots starting at rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PTR_W'(idx);
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/mru_req_arbiter.sv
// ============================================================================
// Module  : mru_req_arbiter
// Brief   : Shares one MRU buffer among N_REQ requesters, one command at a time.
//           Macro MRU_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mru_req_arbiter
   import mru_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 16,
   parameter int BUF_SIZE = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_op,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   mru_en,
   output logic                   mru_set,
   output logic                   mru_get,
   output logic [WIDTH-1:0]       mru_data,
   input  logic [WIDTH-1:0]       mru_rdata
);

   localparam int IDX_W = $clog2(BUF_SIZE);
   localparam int PTR_W = $clog2(N_REQ);

   mru_arb_state_t   state, state_nxt;
   logic [PTR_W-1:0] gnt_idx, gnt_idx_nxt;
   logic             op_q, op_nxt;
   logic [PTR_W-1:0] rr_ptr;

   logic [N_REQ-1:0] pick_grant;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_any;
   logic [WIDTH-1:0] pick_data;
   logic             pick_op;
   logic [N_REQ-1:0] gnt_onehot;

   logic [N_REQ-1:0] req_ready_nxt;
   logic [N_REQ-1:0] rsp_valid_nxt;
   logic [WIDTH-1:0] rsp_data_nxt;
   logic             mru_en_nxt;
   logic             mru_set_nxt;
   logic             mru_get_nxt;
   logic [WIDTH-1:0] mru_data_nxt;

   mru_arb_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any_req   (pick_any)
   );

   assign pick_data  = req_data[pick_idx*WIDTH +: WIDTH];
   assign pick_op    = req_op[pick_idx];
   assign gnt_onehot = N_REQ'(1) << gnt_idx;

   // Outputs are registered, so each state computes what the next state shows.
   always_comb begin
      state_nxt     = state;
      gnt_idx_nxt   = gnt_idx;
      op_nxt        = op_q;
      req_ready_nxt = '0;
      rsp_valid_nxt = '0;
      rsp_data_nxt  = '0;
      mru_en_nxt    = 1'b0;
      mru_set_nxt   = 1'b0;
      mru_get_nxt   = 1'b0;
      mru_data_nxt  = '0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               gnt_idx_nxt   = pick_idx;
               op_nxt        = pick_op;
               state_nxt     = ISSUE;
               req_ready_nxt = pick_grant;
               mru_en_nxt    = 1'b1;
               mru_set_nxt   = (pick_op == MRU_OP_SET);
               mru_get_nxt   = (pick_op == MRU_OP_GET);
               mru_data_nxt  = (pick_op == MRU_OP_SET) ? pick_data
                                                       : WIDTH'(pick_data[IDX_W-1:0]);
            end
         end
         ISSUE: begin
            if (op_q == MRU_OP_SET) begin
               state_nxt     = RESP;
               rsp_valid_nxt = gnt_onehot;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            rsp_data_nxt  = mru_rdata;
            rsp_valid_nxt = gnt_onehot;
            state_nxt     = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt_idx   <= '0;
         op_q      <= MRU_OP_GET;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         mru_en    <= 1'b0;
         mru_set   <= 1'b0;
         mru_get   <= 1'b0;
         mru_data  <= '0;
      end else begin
         state     <= state_nxt;
         gnt_idx   <= gnt_idx_nxt;
         op_q      <= op_nxt;
         req_ready <= req_ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
         mru_en    <= mru_en_nxt;
         mru_set   <= mru_set_nxt;
         mru_get   <= mru_get_nxt;
         mru_data  <= mru_data_nxt;
      end
   end

`ifdef MRU_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   // Pointer advances past the granted requester as the response completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (state == RESP) begin
         rr_ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mru_req_arbiter.sv
// ============================================================================
// Module  : tb_mru_req_arbiter
// Brief   : Directed self-checking bench for mru_req_arbiter with an MRU read model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mru_req_arbiter;

   localparam int N_REQ    = 4;
   localparam int WIDTH    = 16;
   localparam int BUF_SIZE = 8;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [N_REQ-1:0]       req_valid = '0;
   logic [N_REQ-1:0]       req_op = '0;
   logic [N_REQ*WIDTH-1:0] req_data = '0;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]       rsp_data;
   logic                   mru_en;
   logic                   mru_set;
   logic                   mru_get;
   logic [WIDTH-1:0]       mru_data;
   logic [WIDTH-1:0]       mru_rdata = '0;

   logic [WIDTH-1:0]       rd_table [BUF_SIZE];
   int                     checks = 0;
   int                     errors = 0;
   bit                     fixed_prio;

   mru_req_arbiter #(
      .N_REQ    (N_REQ),
      .WIDTH    (WIDTH),
      .BUF_SIZE (BUF_SIZE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .mru_en    (mru_en),
      .mru_set   (mru_set),
      .mru_get   (mru_get),
      .mru_data  (mru_data),
      .mru_rdata (mru_rdata)
   );

   always #5 clk = ~clk;

   // MRU read model: data appears the cycle after a get, junk otherwise.
   always @(posedge clk) begin
      if (mru_en && mru_get)
         mru_rdata <= rd_table[mru_data[2:0]];
      else
         mru_rdata <= 16'h0BAD;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit v, input bit op, input logic [WIDTH-1:0] d);
      req_valid[i]               = v;
      req_op[i]                  = op;
      req_data[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_req_ready"}, 32'(req_ready), 0);
      check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      check_eq({tag, "_rsp_data"},  32'(rsp_data),  0);
      check_eq({tag, "_mru_en"},    32'(mru_en),    0);
      check_eq({tag, "_mru_set"},   32'(mru_set),   0);
      check_eq({tag, "_mru_get"},   32'(mru_get),   0);
      check_eq({tag, "_mru_data"},  32'(mru_data),  0);
   endtask

   initial begin
`ifdef MRU_ARB_FIXED_PRIO_EN
      fixed_prio = 1'b1;
`else
      fixed_prio = 1'b0;
`endif
      for (int k = 0; k < BUF_SIZE; k++) rd_table[k] = 16'h5A00 + 16'(k);
      rd_table[3] = 16'h1234;
      rd_table[1] = 16'hBEEF;

      // Reset state
      step();
      check_all_zero("reset");
      step();
      rst_n = 1'b1;
      step();
      check_eq("idle_rsp_valid", 32'(rsp_valid), 0);

      // Single set from requester 0
      drive(0, 1, 1, 16'h00AA);
      step();
      check_eq("set_req_ready", 32'(req_ready), 32'h1);
      check_eq("set_mru_en",    32'(mru_en),    1);
      check_eq("set_mru_set",   32'(mru_set),   1);
      check_eq("set_mru_get",   32'(mru_get),   0);
      check_eq("set_mru_data",  32'(mru_data),  32'h00AA);
      drive(0, 0, 0, 16'h0);
      step();
      check_eq("set_rsp_valid", 32'(rsp_valid), 32'h1);
      check_eq("set_rsp_data",  32'(rsp_data),  0);
      check_eq("set_mru_en_off", 32'(mru_en),   0);
      step();
      check_eq("set_rsp_clear", 32'(rsp_valid), 0);

      // Single get from requester 2
      drive(2, 1, 0, 16'h0003);
      step();
      check_eq("get_req_ready", 32'(req_ready), 32'h4);
      check_eq("get_mru_get",   32'(mru_get),   1);
      check_eq("get_mru_set",   32'(mru_set),   0);
      check_eq("get_mru_data",  32'(mru_data),  32'h0003);
      drive(2, 0, 0, 16'h0);
      step();
      check_eq("get_wait_rsp",  32'(rsp_valid), 0);
      step();
      check_eq("get_rsp_valid", 32'(rsp_valid), 32'h4);
      check_eq("get_rsp_data",  32'(rsp_data),  32'h1234);
      step();

      // Wrap-around: rr_ptr is 3, requesters 0 and 1 pending
      drive(0, 1, 1, 16'h0011);
      drive(1, 1, 1, 16'h0022);
      step();
      check_eq("wrap_ready0", 32'(req_ready), 32'h1);
      check_eq("wrap_data0",  32'(mru_data),  32'h0011);
      drive(0, 0, 0, 16'h0);
      step();
      check_eq("wrap_rsp0",   32'(rsp_valid), 32'h1);
      step();
      check_eq("wrap_idle",   32'(req_ready), 0);
      step();
      check_eq("wrap_ready1", 32'(req_ready), 32'h2);
      check_eq("wrap_data1",  32'(mru_data),  32'h0022);
      drive(1, 0, 0, 16'h0);
      step();
      check_eq("wrap_rsp1",   32'(rsp_valid), 32'h2);
      step();

      // Index masking: get 0xFFF9 from requester 3 reads index 1
      drive(3, 1, 0, 16'hFFF9);
      step();
      check_eq("mask_ready",    32'(req_ready), 32'h8);
      check_eq("mask_mru_data", 32'(mru_data),  32'h0001);
      drive(3, 0, 0, 16'h0);
      step();
      step();
      check_eq("mask_rsp_valid", 32'(rsp_valid), 32'h8);
      check_eq("mask_rsp_data",  32'(rsp_data),  32'hBEEF);
      step();

      // Contention: all four hold sets from reset
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < N_REQ; i++) drive(i, 1, 1, 16'h0100 + 16'(i));
      for (int i = 0; i < N_REQ; i++) begin
         int e;
         e = fixed_prio ? 0 : i;
         step();
         check_eq($sformatf("cont_ready%0d", i), 32'(req_ready), 32'(1 << e));
         check_eq($sformatf("cont_data%0d", i),  32'(mru_data),  32'h0100 + 32'(e));
         step();
         check_eq($sformatf("cont_rsp%0d", i),   32'(rsp_valid), 32'(1 << e));
         if (!fixed_prio) drive(i, 0, 0, 16'h0);
         step();
         check_eq($sformatf("cont_gap%0d", i),   32'(req_ready), 0);
      end
      req_valid = '0;
      step();
      step();
      step();

      // Move rr_ptr to 3 so a lost pointer reset would be visible
      drive(2, 1, 1, 16'h0077);
      step();
      check_eq("pre_rst_ready", 32'(req_ready), 32'h4);
      drive(2, 0, 0, 16'h0);
      step();
      step();

      // Reset during WAIT
      drive(1, 1, 0, 16'h0002);
      step();
      check_eq("rw_ready", 32'(req_ready), 32'h2);
      check_eq("rw_get",   32'(mru_get),   1);
      drive(1, 0, 0, 16'h0);
      step();
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_wait");
      step();
      rst_n = 1'b1;
      step();
      check_eq("rw_no_rsp", 32'(rsp_valid), 0);
      drive(0, 1, 1, 16'h0030);
      drive(3, 1, 1, 16'h0033);
      step();
      check_eq("rw_next_grant", 32'(req_ready), 32'h1);
      check_eq("rw_next_rsp",   32'(rsp_valid), 0);
      drive(0, 0, 0, 16'h0);
      step();
      check_eq("rw_rsp0", 32'(rsp_valid), 32'h1);
      step();
      step();
      check_eq("rw_ready3", 32'(req_ready), 32'h8);
      drive(3, 0, 0, 16'h0);
      step();
      step();

      // Reset during ISSUE clears the command at once
      drive(1, 1, 1, 16'h0055);
      step();
      check_eq("ri_mru_en", 32'(mru_en), 1);
      rst_n = 1'b0;
      #1;
      check_eq("ri_mru_en_off", 32'(mru_en),    0);
      check_eq("ri_ready_off",  32'(req_ready), 0);
      check_eq("ri_data_off",   32'(mru_data),  0);
      drive(1, 0, 0, 16'h0);
      step();
      rst_n = 1'b1;
      step();
      check_eq("ri_no_rsp", 32'(rsp_valid), 0);
      step();
      check_eq("ri_no_rsp2", 32'(rsp_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
